// File: rtl/rx_frame_drop_fifo.sv
// Store-and-forward RX frame buffer: releases only complete, error-free frames and drops
// errored or overflowing frames whole. The input side is never back-pressured.
module rx_frame_drop_fifo #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                    net_clk,
  input  logic                    sys_reset,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic [CNT_WIDTH-1:0]    drop_ovf_cnt,
  output logic [CNT_WIDTH-1:0]    drop_err_cnt,
  output logic [CNT_WIDTH-1:0]    frame_cnt
);

  localparam int unsigned KeepW = DATA_WIDTH / 8;
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam int unsigned EntW  = DATA_WIDTH + KeepW + 1;

  localparam logic [1:0] StResync = 2'd0;
  localparam logic [1:0] StIdle   = 2'd1;
  localparam logic [1:0] StPass   = 2'd2;
  localparam logic [1:0] StDrop   = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      commit_ptr_q, commit_ptr_d;
  logic [PtrW-1:0]      commit_dly_q;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [EntW-1:0]      out_ent_q, out_ent_d;
  logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0] frm_cnt_q, frm_cnt_d;
  logic [EntW-1:0]      mem_q [DEPTH];

  logic full, wr_en, inc_ovf, inc_err, inc_frm, avail, load;

  assign full = (wr_ptr_q - rd_ptr_q) == PtrW'(DEPTH);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wr_en        = 1'b0;
    inc_ovf      = 1'b0;
    inc_err      = 1'b0;
    inc_frm      = 1'b0;
    case (state_q)
      StResync: begin
        if (!s_axis_tvalid || s_axis_tlast) state_d = StIdle;
      end
      StIdle, StPass: begin
        if (s_axis_tvalid) begin
          if (full) begin
            // In IDLE wr_ptr already equals commit_ptr, so the rewind is harmless there.
            wr_ptr_d = commit_ptr_q;
            if (s_axis_tlast) begin
              inc_ovf = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StDrop;
            end
          end else if (!s_axis_tlast) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PtrW'(1);
            state_d  = StPass;
          end else if (s_axis_tuser) begin
            wr_ptr_d = commit_ptr_q;
            inc_err  = 1'b1;
            state_d  = StIdle;
          end else begin
            wr_en        = 1'b1;
            wr_ptr_d     = wr_ptr_q + PtrW'(1);
            commit_ptr_d = wr_ptr_q + PtrW'(1);
            inc_frm      = 1'b1;
            state_d      = StIdle;
          end
        end
      end
      default: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          inc_ovf = 1'b1;
          state_d = StIdle;
        end
      end
    endcase
  end

  // Reads are gated by a one-cycle-delayed commit pointer so a frame surfaces two edges
  // after its last beat is accepted; the delayed copy is always conservative.
  assign avail = rd_ptr_q != commit_dly_q;
  assign load  = avail && (!out_valid_q || m_axis_tready);

  always_comb begin
    rd_ptr_d    = rd_ptr_q + PtrW'(load);
    out_ent_d   = load ? mem_q[rd_ptr_q[AddrW-1:0]] : out_ent_q;
    out_valid_d = load ? 1'b1 : (out_valid_q && !m_axis_tready);
    ovf_cnt_d   = (inc_ovf && !(&ovf_cnt_q)) ? ovf_cnt_q + CNT_WIDTH'(1) : ovf_cnt_q;
    err_cnt_d   = (inc_err && !(&err_cnt_q)) ? err_cnt_q + CNT_WIDTH'(1) : err_cnt_q;
    frm_cnt_d   = (inc_frm && !(&frm_cnt_q)) ? frm_cnt_q + CNT_WIDTH'(1) : frm_cnt_q;
  end

  always_ff @(posedge net_clk) begin
    if (wr_en) mem_q[wr_ptr_q[AddrW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  always_ff @(posedge net_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q      <= StResync;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      commit_dly_q <= '0;
      rd_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_ent_q    <= '0;
      ovf_cnt_q    <= '0;
      err_cnt_q    <= '0;
      frm_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      commit_dly_q <= commit_ptr_q;
      rd_ptr_q     <= rd_ptr_d;
      out_valid_q  <= out_valid_d;
      out_ent_q    <= out_ent_d;
      ovf_cnt_q    <= ovf_cnt_d;
      err_cnt_q    <= err_cnt_d;
      frm_cnt_q    <= frm_cnt_d;
    end
  end

  assign s_axis_tready = ~sys_reset;
  assign m_axis_tvalid = out_valid_q;
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = out_ent_q;
  assign drop_ovf_cnt  = ovf_cnt_q;
  assign drop_err_cnt  = err_cnt_q;
  assign frame_cnt     = frm_cnt_q;

endmodule
